// File: rtl/inv_cipher_iter_pkg.sv
// inv_cipher_iter_pkg: shared AES-128 types, round constants, inverse S-box and GF(2^8) helpers
// Byte layout everywhere: state[column][row]; byte 0 = state[0][0] sits in the MSBs.
package inv_cipher_iter_pkg;

    localparam int NR = 10;
    localparam int NK = 4;
    localparam int NW = 4 * (NR + 1);

    typedef logic [0:3][7:0]      word_t;
    typedef logic [0:3][0:3][7:0] state_t;
    typedef word_t [0:NW-1]       keySched_t;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} fsmState_t;

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // Multiply by x modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Shift-and-add GF(2^8) multiply; with a constant operand it folds to a few XORs.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? (p ^ x) : p;
            x = xtime(x);
        end
        return p;
    endfunction

endpackage

// File: rtl/addRoundKey.sv
// addRoundKey: XOR a 128-bit round key into the cipher state
// Ports: st (state in), rk (round key), o (state out).
module addRoundKey
    import inv_cipher_iter_pkg::*;
(
    input  state_t st,
    input  state_t rk,
    output state_t o
);

    assign o = st ^ rk;

endmodule

// File: rtl/inv_round.sv
// inv_round: one combinational AES inverse round
// InvShiftRows -> InvSubBytes -> AddRoundKey, then InvMixColumns unless skipMix (final round).
// Ports: st (state in), rk (round key), skipMix (bypass InvMixColumns), o (state out).
module inv_round
    import inv_cipher_iter_pkg::*;
(
    input  state_t st,
    input  state_t rk,
    input  logic   skipMix,
    output state_t o
);

    state_t sub;
    state_t ark;
    state_t mix;

    // Row r rotates right by r columns, so column c takes its row-r byte from column c-r.
    always_comb begin
        sub = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sub[c][r] = INV_SBOX[st[(c + 4 - r) % 4][r]];
    end

    addRoundKey uArk (
        .st (sub),
        .rk (rk),
        .o  (ark)
    );

    // Circulant {0e,0b,0d,09}: row r starts its coefficient pattern at column byte r.
    always_comb begin
        mix = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                mix[c][r] = gmul(ark[c][r], 8'h0e) ^ gmul(ark[c][(r + 1) % 4], 8'h0b)
                          ^ gmul(ark[c][(r + 2) % 4], 8'h0d) ^ gmul(ark[c][(r + 3) % 4], 8'h09);
    end

    assign o = skipMix ? ark : mix;

endmodule

// File: rtl/keyExpansion.sv
// keyExpansion: combinational AES-128 key schedule, 44 words from the cipher key
// Ports: key (cipher key, word c = key[c]), w (expanded schedule, word i = w[i]).
module keyExpansion
    import inv_cipher_iter_pkg::*;
(
    input  state_t    key,
    output keySched_t w
);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:9][7:0] RCON = {
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    always_comb begin
        word_t t;
        t = '0;
        w = '0;
        for (int i = 0; i < NW; i++) begin
            if (i < NK) begin
                w[i] = key[i];
            end else begin
                t = w[i-1];
                if (i % NK == 0) begin
                    // RotWord then SubWord, Rcon into the leading byte
                    t = {SBOX[t[1]], SBOX[t[2]], SBOX[t[3]], SBOX[t[0]]};
                    t[0] = t[0] ^ RCON[i/NK-1];
                end
                w[i] = w[i-NK] ^ t;
            end
        end
    end

endmodule

// File: rtl/inv_cipher_iter.sv
// inv_cipher_iter: iterative AES-128 decryptor, one round per clock, one block in flight
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    ciphertext+key handshake; data, key latched on accept
//   out_valid/out_ready  plaintext handshake; o held stable while out_valid && !out_ready
//   data, key, o         128-bit blocks laid out [column][row], byte 0 = [0][0]
module inv_cipher_iter
    import inv_cipher_iter_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   in_valid,
    output logic   in_ready,
    input  state_t data,
    input  state_t key,
    output logic   out_valid,
    input  logic   out_ready,
    output state_t o
);

    localparam logic [3:0] NR_CNT = 4'(NR);

    fsmState_t  fsm;
    logic [3:0] roundCnt;
    logic [5:0] rkIdx;
    state_t     stR;
    state_t     keyR;
    state_t     rk;
    state_t     arkOut;
    state_t     roundOut;
    keySched_t  w;

    keyExpansion uKeyExp (
        .key (keyR),
        .w   (w)
    );

    // Round key r is schedule words 4r..4r+3.
    assign rkIdx = {roundCnt, 2'b00};
    assign rk    = w[rkIdx +: 4];

    addRoundKey uArk (
        .st (stR),
        .rk (rk),
        .o  (arkOut)
    );

    inv_round uRound (
        .st      (stR),
        .rk      (rk),
        .skipMix (roundCnt == 4'd0),
        .o       (roundOut)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm       <= IDLE;
            roundCnt  <= 4'd0;
            stR       <= '0;
            keyR      <= '0;
            o         <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (fsm)
                IDLE: if (in_valid) begin
                    stR      <= data;
                    keyR     <= key;
                    roundCnt <= NR_CNT;
                    in_ready <= 1'b0;
                    fsm      <= BUSY;
                end
                BUSY: if (roundCnt == NR_CNT) begin
                    stR      <= arkOut;
                    roundCnt <= roundCnt - 4'd1;
                end else if (roundCnt != 4'd0) begin
                    stR      <= roundOut;
                    roundCnt <= roundCnt - 4'd1;
                end else begin
                    o         <= roundOut;
                    out_valid <= 1'b1;
                    fsm       <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    fsm       <= IDLE;
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inv_cipher_iter.sv
// tb_inv_cipher_iter: directed + round-trip bench for inv_cipher_iter with a plaintext scoreboard
module tb_inv_cipher_iter;
    import inv_cipher_iter_pkg::*;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    // Accept edge closes cycle T; out_valid is visible from cycle T+12, i.e. after 11 more edges.
    localparam int LAT = 11;

    logic   clk = 1'b0;
    logic   rst_n;
    logic   in_valid;
    logic   in_ready;
    logic   out_valid;
    logic   out_ready;
    state_t data;
    state_t key;
    state_t o;

    int compared   = 0;
    int mismatched = 0;
    logic [127:0] sb[$];
    logic [7:0]   sbT[256];

    inv_cipher_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data      (data),
        .key       (key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .o         (o)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] tXtime(input logic [7:0] b);
        return b[7] ? ({b[6:0], 1'b0} ^ 8'h1b) : {b[6:0], 1'b0};
    endfunction

    function automatic logic [7:0] tMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = tXtime(x);
        end
        return p;
    endfunction

    // Forward S-box from first principles: multiplicative inverse then the affine map.
    function automatic logic [7:0] tSbox(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        logic [7:0] s;
        logic [7:0] q;
        if (x != 8'h00) begin
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = tMul(inv, x);
        end
        s = inv;
        q = inv;
        for (int k = 0; k < 4; k++) begin
            q = {q[6:0], q[7]};
            s = s ^ q;
        end
        return s ^ 8'h63;
    endfunction

    // Reference encryptor (FIPS-197 Cipher) used to build round-trip vectors.
    function automatic logic [127:0] aesEnc(input logic [127:0] pt, input logic [127:0] k);
        logic [31:0]  w[44];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [7:0]   s[16];
        logic [7:0]   t[16];
        logic [7:0]   a[4];
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbT[tmp[31:24]] ^ rc, sbT[tmp[23:16]], sbT[tmp[15:8]], sbT[tmp[7:0]]};
                rc = tXtime(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sbT[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
            if (rnd < 10)
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) a[r] = s[4*c+r];
                    for (int r = 0; r < 4; r++)
                        s[4*c+r] = tMul(a[r], 8'h02) ^ tMul(a[(r+1)%4], 8'h03) ^ a[(r+2)%4] ^ a[(r+3)%4];
                end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a block and wait (bounded) for it to be accepted; the scoreboard gets its plaintext.
    task automatic send(input logic [127:0] ct, input logic [127:0] k, input logic [127:0] pt,
                        input bit keepValid);
        int n = 0;
        data = ct;
        key = k;
        in_valid = 1'b1;
        while (!in_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("accept_ready", in_ready, 1);
        @(posedge clk); #1;
        sb.push_back(pt);
        if (!keepValid) in_valid = 1'b0;
    endtask

    task automatic waitValid(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("out_valid_seen", out_valid, 1);
    endtask

    // Compare against the scoreboard head, then complete the output handshake.
    task automatic take(input string tag);
        logic [127:0] e = 'x;
        if (sb.size() > 0) e = sb.pop_front();
        check(tag, o, e);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_drop"}, out_valid, 0);
        check({tag, "_idle"}, in_ready, 1);
    endtask

    initial begin
        int n;
        logic [127:0] rk;
        logic [127:0] rp;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        data = '0;
        key = '0;
        for (int x = 0; x < 256; x++) sbT[x] = tSbox(8'(x));
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_o", o, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        send(C1, K1, P1, 0);
        check("t1_busy_ready", in_ready, 0);
        waitValid(n);
        check("t1_latency", 128'(n), 128'(LAT));
        take("t1_pt");

        send(C2, K2, P2, 0);
        waitValid(n);
        take("t2_pt");

        send(C1, K1, P1, 0);
        waitValid(n);
        for (int i = 0; i < 20; i++) begin
            check("t3_hold_o", o, P1);
            check("t3_hold_valid", out_valid, 1);
            check("t3_hold_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        take("t3_pt");
        @(posedge clk); #1;
        check("t3_single_xfer", out_valid, 0);

        send(C1, K1, P1, 1);
        n = 0;
        while (!out_valid && n < 40) begin
            data = {$urandom(), $urandom(), $urandom(), $urandom()};
            key = {$urandom(), $urandom(), $urandom(), $urandom()};
            check("t4_no_accept", in_ready, 0);
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        check("t4_valid", out_valid, 1);
        take("t4_pt");

        send(C1, K1, P1, 0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", out_valid, 0);
        check("t5_rst_ready", in_ready, 1);
        check("t5_rst_o", o, 0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("t5_post_ready", in_ready, 1);
        check("t5_post_valid", out_valid, 0);
        send(C2, K2, P2, 0);
        waitValid(n);
        take("t5_pt");

        for (int i = 0; i < 200; i++) begin
            rk = {$urandom(), $urandom(), $urandom(), $urandom()};
            rp = {$urandom(), $urandom(), $urandom(), $urandom()};
            send(aesEnc(rp, rk), rk, rp, 0);
            waitValid(n);
            take("t6_roundtrip");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
